rob_queue_ctrl: RTL and testbench
=================================

Name: rob_queue_ctrl

Overview:
Pointer and status controller for the reorder buffer.
- Owns head/tail pointers and per-entry valid/done bitmaps.
- Drives the per-line write enable of the ROB storage lines.
- Hands entry indices to issue (allocate), accepts completion marks from writeback, and presents the in-order head entry to the commit stage.
- Sits between decode/issue (upstream) and the ROB line array plus commit logic (downstream).

Parameters:
- ROB_ADDR_WIDTH, 4, index width.
- ROB_DEPTH, 16, number of entries; must equal 2**ROB_ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  discard all entries (exception or mispredict).
- alloc_valid  in  1  issue requests one entry.
- alloc_ready  out  1  entry available this cycle.
- alloc_idx  out  ROB_ADDR_WIDTH  index granted (current tail).
- line_write_en  out  ROB_DEPTH  one-hot write enable to ROB lines.
- wb_valid  in  1  writeback completion.
- wb_idx  in  ROB_ADDR_WIDTH  completed entry index.
- commit_valid  out  1  head entry valid and done.
- commit_idx  out  ROB_ADDR_WIDTH  head index.
- commit_ready  in  1  commit stage accepts head.
- count  out  ROB_ADDR_WIDTH+1  occupied entries.
- full  out  1  count == ROB_DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst low, asynchronous), with the same effect as flush:
  - head=0, tail=0, count=0; valid and done bitmaps all zero.
  - alloc_ready=1, alloc_idx=0, commit_valid=0, commit_idx=0, full=0, empty=1, line_write_en=0.
- Pointers are ROB_ADDR_WIDTH+1 bits; the extra MSB is a wrap bit.
  - full when index bits are equal and wrap bits differ; empty when pointers are equal.
  - Index wraps from ROB_DEPTH-1 to 0 and toggles the wrap bit.
- Allocate:
  - alloc_ready = !full, combinational from registered state only; no same-cycle bypass from commit.
  - Fire = alloc_valid && alloc_ready. alloc_idx = tail index.
  - line_write_en[tail] = fire, combinational, same cycle.
  - On the clock edge: valid[tail]=1, done[tail]=0, tail+1.
- Writeback:
  - wb_valid with valid[wb_idx]=1 sets done[wb_idx] on the edge.
  - wb_valid to an invalid entry is ignored (no error).
  - wb to the entry being allocated in the same cycle is ignored; allocation clears done.
- Commit:
  - commit_valid = valid[head] && done[head]; commit_idx = head index.
  - Fire = commit_valid && commit_ready → valid[head]=0, done[head]=0, head+1.
  - wb_valid to head in the same cycle does not make commit_valid true that cycle; done is visible one cycle later.
- count:
  - Alloc fire and commit fire together: count unchanged, both pointers advance.
  - When full, commit fire frees an entry; alloc is possible only the next cycle.
- Flush (synchronous, highest priority):
  - On the edge it has the same effect as reset; alloc, wb and commit in that cycle are discarded.
  - line_write_en is forced to 0 in the flush cycle.
- Latency: allocation to commit_valid is at least 2 cycles (alloc edge, wb edge, then visible).

Optional Feature:
- ROB_STALL_CNT_EN defined:
  - Adds output alloc_stall_cnt, 32 bits.
  - Increments each cycle alloc_valid && !alloc_ready; saturates at 32'hFFFFFFFF.
  - Cleared by reset only, not by flush.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header (next to bus.v): ROB_ADDR_BUS and ROB_PTR_BUS width macros, ROB_DEPTH constant.
- One natural sub-module, rob_ptr (the pointer counter):
  - Wrap-bit pointer with increment enable and synchronous clear.
  - Instantiated twice, for head and tail.

Test Plan:
- Reset then idle → empty=1, full=0, alloc_ready=1, alloc_idx=0, commit_valid=0, line_write_en=0.
- 16 consecutive allocs with no commit:
  - alloc_idx steps 0..15; line_write_en one-hot matches alloc_idx.
  - Then full=1, alloc_ready=0, count=16.
- Alloc 0,1,2; wb idx 1 then idx 0:
  - commit_valid stays 0 until done[0] is set, then commits idx 0 and idx 1 in order.
  - idx 2 is held until its wb.
- Full ROB, head done, commit_ready and alloc_valid asserted together:
  - Commit fires, alloc is refused that cycle, alloc succeeds the next cycle with alloc_idx=old head.
  - count returns to 16.
- Flush with 5 entries and a simultaneous alloc/wb/commit → next cycle empty=1, head=tail=0, line_write_en was 0 in the flush cycle.
- Wrap-around: 40 alloc/wb/commit streams at steady state → indices wrap 15→0 with no spurious full/empty.
  - With ROB_STALL_CNT_EN, 3 stalled alloc cycles → alloc_stall_cnt=3.

Source files
------------

// File: rtl/rob_queue_ctrl_pkg.sv
// Shared widths and depth for the reorder-buffer pointer/status controller.
package rob_queue_ctrl_pkg;

    // Index width of a ROB entry
    localparam int unsigned ROB_ADDR_BUS_W = 4;
    // Pointer width: index plus one wrap bit
    localparam int unsigned ROB_PTR_BUS_W  = ROB_ADDR_BUS_W + 1;
    // Number of ROB entries
    localparam int unsigned ROB_DEPTH_DEF  = 1 << ROB_ADDR_BUS_W;

endpackage

// File: rtl/rob_queue_ctrl_ptr.sv
// Wrap-bit pointer: ADDR_W index bits plus one wrap bit, increment enable,
// synchronous clear. Depth is a power of two, so a plain +1 wraps the index
// from its maximum back to 0 and toggles the wrap bit in one step.
module rob_ptr #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [ADDR_W:0] ptr
);

    // Pointer register: clear has priority over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/rob_queue_ctrl.sv
// Reorder-buffer pointer and status controller: head/tail pointers,
// per-entry valid/done bitmaps, one-hot line write enable, in-order commit.
// Optional macro ROB_STALL_CNT_EN adds a saturating alloc_stall_cnt output.
module rob_queue_ctrl
    import rob_queue_ctrl_pkg::*;
#(
    parameter int unsigned ROB_ADDR_WIDTH = ROB_ADDR_BUS_W,
    parameter int unsigned ROB_DEPTH      = ROB_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    output logic [ROB_ADDR_WIDTH-1:0] alloc_idx,
    output logic [ROB_DEPTH-1:0]      line_write_en,
    input  logic                      wb_valid,
    input  logic [ROB_ADDR_WIDTH-1:0] wb_idx,
    output logic                      commit_valid,
    output logic [ROB_ADDR_WIDTH-1:0] commit_idx,
    input  logic                      commit_ready,
    output logic [ROB_ADDR_WIDTH:0]   count,
    output logic                      full,
`ifdef ROB_STALL_CNT_EN
    output logic [31:0]               alloc_stall_cnt,
`endif
    output logic                      empty
);

    logic [ROB_ADDR_WIDTH:0]   head_ptr;
    logic [ROB_ADDR_WIDTH:0]   tail_ptr;
    logic [ROB_ADDR_WIDTH-1:0] head_idx;
    logic [ROB_ADDR_WIDTH-1:0] tail_idx;
    logic [ROB_DEPTH-1:0]      valid_q;
    logic [ROB_DEPTH-1:0]      done_q;
    logic                      alloc_fire;
    logic                      commit_fire;
    logic                      wb_hit;

    rob_ptr #(.ADDR_W(ROB_ADDR_WIDTH)) u_head_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (commit_fire),
        .ptr (head_ptr)
    );

    rob_ptr #(.ADDR_W(ROB_ADDR_WIDTH)) u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (alloc_fire),
        .ptr (tail_ptr)
    );

    // Status, handshakes and line write enable from registered state only
    always_comb begin
        head_idx      = head_ptr[ROB_ADDR_WIDTH-1:0];
        tail_idx      = tail_ptr[ROB_ADDR_WIDTH-1:0];
        full          = (head_idx == tail_idx) &&
                        (head_ptr[ROB_ADDR_WIDTH] != tail_ptr[ROB_ADDR_WIDTH]);
        empty         = (head_ptr == tail_ptr);
        count         = tail_ptr - head_ptr;
        alloc_ready   = !full;
        alloc_idx     = tail_idx;
        commit_idx    = head_idx;
        commit_valid  = valid_q[head_idx] && done_q[head_idx];
        alloc_fire    = alloc_valid && alloc_ready && !flush;
        commit_fire   = commit_valid && commit_ready && !flush;
        wb_hit        = wb_valid && valid_q[wb_idx] &&
                        !(alloc_fire && (wb_idx == tail_idx));
        line_write_en = '0;
        if (alloc_fire) begin
            line_write_en[tail_idx] = 1'b1;
        end
    end

    // Valid/done bitmaps; commit clears after writeback so a same-cycle
    // wb to the committing head cannot leave a stale done bit behind
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (wb_hit) begin
                done_q[wb_idx] <= 1'b1;
            end
            if (commit_fire) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
            end
            if (alloc_fire) begin
                valid_q[tail_idx] <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
            end
        end
    end

`ifdef ROB_STALL_CNT_EN
    // Saturating count of refused allocation requests; survives flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_stall_cnt <= '0;
        end else if (alloc_valid && !alloc_ready && (alloc_stall_cnt != '1)) begin
            alloc_stall_cnt <= alloc_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_queue_ctrl.sv
// Directed self-checking bench for rob_queue_ctrl.
module tb_rob_queue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_idx;
    logic [15:0] line_write_en;
    logic        wb_valid;
    logic [3:0]  wb_idx;
    logic        commit_valid;
    logic [3:0]  commit_idx;
    logic        commit_ready;
    logic [4:0]  count;
    logic        full;
    logic        empty;
`ifdef ROB_STALL_CNT_EN
    logic [31:0] alloc_stall_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    rob_queue_ctrl #(.ROB_ADDR_WIDTH(4), .ROB_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_idx     (alloc_idx),
        .line_write_en (line_write_en),
        .wb_valid      (wb_valid),
        .wb_idx        (wb_idx),
        .commit_valid  (commit_valid),
        .commit_idx    (commit_idx),
        .commit_ready  (commit_ready),
        .count         (count),
        .full          (full),
`ifdef ROB_STALL_CNT_EN
        .alloc_stall_cnt (alloc_stall_cnt),
`endif
        .empty         (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        wb_valid     = 1'b0;
        wb_idx       = 4'd0;
        commit_ready = 1'b0;
    endtask

    task automatic check_empty_state(input string tag);
        check({tag, "_empty"},  32'(empty), 32'd1);
        check({tag, "_full"},   32'(full), 32'd0);
        check({tag, "_count"},  32'(count), 32'd0);
        check({tag, "_aready"}, 32'(alloc_ready), 32'd1);
        check({tag, "_aidx"},   32'(alloc_idx), 32'd0);
        check({tag, "_cvalid"}, 32'(commit_valid), 32'd0);
        check({tag, "_cidx"},   32'(commit_idx), 32'd0);
        check({tag, "_lwe"},    32'(line_write_en), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        #12;
        check_empty_state("in_reset");
        rst = 1'b1;
        tick();
        check_empty_state("idle");

        // Fill all 16 entries back to back
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            #1;
            check("fill_aidx", 32'(alloc_idx), 32'(i));
            check("fill_lwe", 32'(line_write_en), 32'(1) << i);
            check("fill_aready", 32'(alloc_ready), 32'd1);
            tick();
        end
        #1;
        check("full_flag", 32'(full), 32'd1);
        check("full_aready", 32'(alloc_ready), 32'd0);
        check("full_count", 32'(count), 32'd16);
        check("full_empty", 32'(empty), 32'd0);
        check("full_lwe", 32'(line_write_en), 32'd0);
        // Three refused allocation cycles
        tick();
        tick();
        tick();
        alloc_valid = 1'b0;
        #1;
        check("full_count_hold", 32'(count), 32'd16);
`ifdef ROB_STALL_CNT_EN
        check("stall_cnt", alloc_stall_cnt, 32'd3);
`endif

        // Full: complete head, then commit and alloc together
        wb_valid = 1'b1;
        wb_idx   = 4'd0;
        #1;
        check("wb_same_cycle_cvalid", 32'(commit_valid), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("head_done_cvalid", 32'(commit_valid), 32'd1);
        check("head_done_cidx", 32'(commit_idx), 32'd0);
        commit_ready = 1'b1;
        alloc_valid  = 1'b1;
        #1;
        check("full_commit_aready", 32'(alloc_ready), 32'd0);
        check("full_commit_lwe", 32'(line_write_en), 32'd0);
        tick();
        commit_ready = 1'b0;
        #1;
        check("after_commit_count", 32'(count), 32'd15);
        check("after_commit_aready", 32'(alloc_ready), 32'd1);
        check("after_commit_aidx", 32'(alloc_idx), 32'd0);
        check("after_commit_lwe", 32'(line_write_en), 32'd1);
        check("after_commit_cidx", 32'(commit_idx), 32'd1);
        check("after_commit_cvalid", 32'(commit_valid), 32'd0);
        tick();
        alloc_valid = 1'b0;
        #1;
        check("refill_count", 32'(count), 32'd16);
        check("refill_full", 32'(full), 32'd1);

        // Plain flush from full
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        #1;
        check_empty_state("flush_full");

        // Alloc 0,1,2; wb 1 then 0; in-order commit
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            #1;
            check("ooo_aidx", 32'(alloc_idx), 32'(i));
            tick();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1;
        wb_idx   = 4'd1;
        commit_ready = 1'b1;
        tick();
        #1;
        check("ooo_wb1_cvalid", 32'(commit_valid), 32'd0);
        wb_idx = 4'd0;
        #1;
        check("ooo_wb0_same_cvalid", 32'(commit_valid), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("ooo_c0_cvalid", 32'(commit_valid), 32'd1);
        check("ooo_c0_cidx", 32'(commit_idx), 32'd0);
        tick();
        check("ooo_c1_cvalid", 32'(commit_valid), 32'd1);
        check("ooo_c1_cidx", 32'(commit_idx), 32'd1);
        tick();
        check("ooo_hold2_cvalid", 32'(commit_valid), 32'd0);
        check("ooo_hold2_cidx", 32'(commit_idx), 32'd2);
        check("ooo_hold2_count", 32'(count), 32'd1);
        wb_valid = 1'b1;
        wb_idx   = 4'd2;
        tick();
        wb_valid = 1'b0;
        #1;
        check("ooo_c2_cvalid", 32'(commit_valid), 32'd1);
        check("ooo_c2_cidx", 32'(commit_idx), 32'd2);
        tick();
        commit_ready = 1'b0;
        #1;
        check("ooo_drained_empty", 32'(empty), 32'd1);
        check("ooo_drained_aidx", 32'(alloc_idx), 32'd3);

        // Five entries (3..7), head done, then flush with alloc/wb/commit
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1;
        wb_idx   = 4'd3;
        tick();
        wb_valid = 1'b0;
        #1;
        check("pre_flush_count", 32'(count), 32'd5);
        check("pre_flush_cvalid", 32'(commit_valid), 32'd1);
        flush        = 1'b1;
        alloc_valid  = 1'b1;
        wb_valid     = 1'b1;
        wb_idx       = 4'd4;
        commit_ready = 1'b1;
        #1;
        check("flush_cycle_lwe", 32'(line_write_en), 32'd0);
        tick();
        idle_inputs();
        #1;
        check_empty_state("flush5");

        // Steady stream: alloc k, wb k-1, commit k-2 each cycle
        commit_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            alloc_valid = 1'b1;
            wb_valid    = (k >= 1);
            wb_idx      = 4'((k + 15) % 16);
            #1;
            check("stream_aidx", 32'(alloc_idx), 32'(k % 16));
            check("stream_lwe", 32'(line_write_en), 32'(1) << (k % 16));
            check("stream_cvalid", 32'(commit_valid), 32'(k >= 2));
            if (k >= 2)
                check("stream_cidx", 32'(commit_idx), 32'((k + 14) % 16));
            check("stream_count", 32'(count), 32'((k < 2) ? k : 2));
            check("stream_full", 32'(full), 32'd0);
            check("stream_empty", 32'(empty), 32'(k == 0));
            tick();
        end
        idle_inputs();
        #1;
        check("stream_end_count", 32'(count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
